// File: rtl/accseq_pkg.sv
// Shared types for the accumulator microsequencer: opcodes, FSM states and
// the datapath control word.
package accseq_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_OUT = 3'd4,
    OP_CLR = 3'd5
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH_A,
    ST_LATCH_B,
    ST_EXEC,
    ST_WB,
    ST_OUT
  } state_t;

  // n_la / n_lb are active-low strobes, so the quiet word is not all zeros
  typedef struct packed {
    logic load_bus;
    logic n_la;
    logic n_lb;
    logic ea;
    logic eu;
    logic sub;
  } ctl_word_t;

  localparam ctl_word_t CTL_IDLE = '{
    load_bus: 1'b0, n_la: 1'b1, n_lb: 1'b1, ea: 1'b0, eu: 1'b0, sub: 1'b0
  };

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/accseq_if.sv
// Instruction and result handshake channels of the accumulator sequencer.
// master = instruction producer / result consumer, slave = sequencer.
interface accseq_if #(
  parameter int DATA_W = 8
);

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [DATA_W-1:0] instr_data;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output instr_valid, instr_op, instr_data, result_ready,
    input  instr_ready, result_valid
  );

  modport slave (
    input  instr_valid, instr_op, instr_data, result_ready,
    output instr_ready, result_valid
  );

endinterface

// File: rtl/accseq_ctl_decode.sv
// Pure combinational map from registered (state, op) to the datapath
// control word; no sequencer inputs reach the control lines directly.
module accseq_ctl_decode
  import accseq_pkg::*;
(
  input  state_t    state,
  input  opcode_t   op,
  output ctl_word_t ctl
);

  always_comb begin
    ctl = CTL_IDLE;
    case (state)
      ST_DRIVE: begin
        ctl.load_bus = 1'b1;
      end
      ST_LATCH_A: begin
        ctl.load_bus = 1'b1;
        ctl.n_la     = 1'b0;
      end
      ST_LATCH_B: begin
        ctl.load_bus = 1'b1;
        ctl.n_lb     = 1'b0;
      end
      ST_EXEC: begin
        ctl.eu  = 1'b1;
        ctl.sub = (op == OP_SUB);
      end
      // ALU result stays on the bus while A captures it
      ST_WB: begin
        ctl.eu   = 1'b1;
        ctl.sub  = (op == OP_SUB);
        ctl.n_la = 1'b0;
      end
      ST_OUT: begin
        ctl.ea = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accum_sequencer.sv
// Microsequencer stepping the accumulator datapath through fixed T-states.
// Optional macro ACCSEQ_PERF_EN adds retired/stall performance counters.
module accum_sequencer
  import accseq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OUT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  accseq_if.slave           bus,
  output logic [DATA_W-1:0] operand_o,
  output logic              ctl_load_bus,
  output logic              ctl_n_la,
  output logic              ctl_n_lb,
  output logic              ctl_ea,
  output logic              ctl_eu,
  output logic              ctl_sub,
  input  logic              alu_cf,
  input  logic              alu_zf,
  output logic              flag_c,
  output logic              flag_z,
  output logic              err
`ifdef ACCSEQ_PERF_EN
  ,
  output logic [15:0]       retired_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = (OUT_TIMEOUT < 2) ? 1 : $clog2(OUT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((OUT_TIMEOUT > 0) ? OUT_TIMEOUT - 1 : 0);

  state_t            state;
  opcode_t           op_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  to_cnt;
  ctl_word_t         ctl;
  opcode_t           op_in;

  assign op_in            = opcode_t'(bus.instr_op);
  assign bus.instr_ready  = rst_n && (state == ST_IDLE);
  assign bus.result_valid = (state == ST_OUT);
  assign operand_o        = data_q;

  accseq_ctl_decode u_decode (
    .state (state),
    .op    (op_q),
    .ctl   (ctl)
  );

  assign ctl_load_bus = ctl.load_bus;
  assign ctl_n_la     = ctl.n_la;
  assign ctl_n_lb     = ctl.n_lb;
  assign ctl_ea       = ctl.ea;
  assign ctl_eu       = ctl.eu;
  assign ctl_sub      = ctl.sub;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_NOP;
      data_q <= '0;
      to_cnt <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            if (!op_is_legal(bus.instr_op)) begin
              err <= 1'b1;
            end else begin
              op_q   <= op_in;
              data_q <= (op_in == OP_CLR) ? '0 : bus.instr_data;
              to_cnt <= '0;
              case (op_in)
                OP_LDA, OP_CLR, OP_ADD, OP_SUB: state <= ST_DRIVE;
                OP_OUT:                         state <= ST_OUT;
                default:                        state <= ST_IDLE;
              endcase
            end
          end
        end
        ST_DRIVE: begin
          state <= (op_q == OP_ADD || op_q == OP_SUB) ? ST_LATCH_B : ST_LATCH_A;
        end
        ST_LATCH_A: state <= ST_IDLE;
        ST_LATCH_B: state <= ST_EXEC;
        ST_EXEC:    state <= ST_WB;
        ST_WB: begin
          flag_c <= alu_cf;
          flag_z <= alu_zf;
          state  <= ST_IDLE;
        end
        // With OUT_TIMEOUT = 0 the counter never advances and OUT waits forever
        ST_OUT: begin
          if (bus.result_ready) begin
            state <= ST_IDLE;
          end else if (OUT_TIMEOUT > 0) begin
            if (to_cnt == TO_LAST) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACCSEQ_PERF_EN
  logic retire;

  // A timed-out OUT is abandoned, not retired
  assign retire = (state == ST_LATCH_A) || (state == ST_WB) ||
                  ((state == ST_OUT) && bus.result_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) begin
        retired_cnt <= retired_cnt + 16'd1;
      end
      if ((state == ST_OUT) && !bus.result_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboard bench for accum_sequencer: stimulus queues expected non-idle
// cycles, negedge monitors pop and compare. dut0 waits forever, dut3 times out.
module tb_accum_sequencer;
  import accseq_pkg::*;

  // Control word order: {load_bus, n_la, n_lb, ea, eu, sub}
  localparam logic [5:0] C_IDLE   = 6'b011000;
  localparam logic [5:0] C_DRIVE  = 6'b111000;
  localparam logic [5:0] C_LA     = 6'b101000;
  localparam logic [5:0] C_LB     = 6'b110000;
  localparam logic [5:0] C_EXEC   = 6'b011010;
  localparam logic [5:0] C_EXEC_S = 6'b011011;
  localparam logic [5:0] C_WB     = 6'b001010;
  localparam logic [5:0] C_WB_S   = 6'b001011;
  localparam logic [5:0] C_OUT    = 6'b011100;

  typedef struct packed {
    logic [5:0] ctl;
    logic [7:0] operand;
    logic       rv;
    logic       err;
  } ev_t;

  typedef struct packed {
    ev_t  ev;
    logic chk_op;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic alu_cf, alu_zf;
  logic mon_en = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t q0[$];
  exp_t q3[$];

  logic [7:0] opnd0, opnd3;
  logic ld0, nla0, nlb0, ea0, eu0, sub0, fc0, fz0, err0;
  logic ld3, nla3, nlb3, ea3, eu3, sub3, fc3, fz3, err3;
  logic [5:0] ctl0, ctl3;
`ifdef ACCSEQ_PERF_EN
  logic [15:0] ret0, stall0, ret3, stall3;
`endif

  assign ctl0 = {ld0, nla0, nlb0, ea0, eu0, sub0};
  assign ctl3 = {ld3, nla3, nlb3, ea3, eu3, sub3};

  accseq_if #(.DATA_W(8)) bus0 ();
  accseq_if #(.DATA_W(8)) bus3 ();

  always #5 clk = ~clk;

  accum_sequencer #(.DATA_W(8), .OUT_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .operand_o(opnd0),
    .ctl_load_bus(ld0), .ctl_n_la(nla0), .ctl_n_lb(nlb0), .ctl_ea(ea0),
    .ctl_eu(eu0), .ctl_sub(sub0), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .flag_c(fc0), .flag_z(fz0), .err(err0)
`ifdef ACCSEQ_PERF_EN
    , .retired_cnt(ret0), .stall_cnt(stall0)
`endif
  );

  accum_sequencer #(.DATA_W(8), .OUT_TIMEOUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .operand_o(opnd3),
    .ctl_load_bus(ld3), .ctl_n_la(nla3), .ctl_n_lb(nlb3), .ctl_ea(ea3),
    .ctl_eu(eu3), .ctl_sub(sub3), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .flag_c(fc3), .flag_z(fz3), .err(err3)
`ifdef ACCSEQ_PERF_EN
    , .retired_cnt(ret3), .stall_cnt(stall3)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushEv(input logic [5:0] c, input logic [7:0] d, input logic rv, input logic e, input logic chk);
    q0.push_back('{ev: '{ctl: c, operand: d, rv: rv, err: e}, chk_op: chk});
  endtask

  task automatic pushEv3(input logic [5:0] c, input logic [7:0] d, input logic rv, input logic e, input logic chk);
    q3.push_back('{ev: '{ctl: c, operand: d, rv: rv, err: e}, chk_op: chk});
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data);
    @(negedge clk);
    checkOutput("instr_ready before accept", 32'(bus0.instr_ready), 32'd1);
    bus0.instr_valid = 1'b1;
    bus0.instr_op    = op;
    bus0.instr_data  = data;
    @(posedge clk);
    #1 bus0.instr_valid = 1'b0;
  endtask

  task automatic waitReady(input int exp_lat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.instr_ready && n < 20);
    checkOutput(name, 32'(n), 32'(exp_lat));
  endtask

  // Monitor for dut0: every cycle that is not quiet must match the queue head
  always @(negedge clk) begin
    if (mon_en && (ctl0 !== C_IDLE || bus0.result_valid !== 1'b0 || err0 !== 1'b0)) begin
      ev_t act;
      exp_t e;
      act = '{ctl: ctl0, operand: opnd0, rv: bus0.result_valid, err: err0};
      if (q0.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL dut0 unexpected event: got 0x%0h, expected none", act);
      end else begin
        e = q0.pop_front();
        if (!e.chk_op) act.operand = e.ev.operand;
        checkOutput("dut0 event", {16'h0, act}, {16'h0, e.ev});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && (ctl3 !== C_IDLE || bus3.result_valid !== 1'b0 || err3 !== 1'b0)) begin
      ev_t act;
      exp_t e;
      act = '{ctl: ctl3, operand: opnd3, rv: bus3.result_valid, err: err3};
      if (q3.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL dut3 unexpected event: got 0x%0h, expected none", act);
      end else begin
        e = q3.pop_front();
        if (!e.chk_op) act.operand = e.ev.operand;
        checkOutput("dut3 event", {16'h0, act}, {16'h0, e.ev});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    alu_cf = 1'b0;
    alu_zf = 1'b0;
    bus0.instr_valid = 1'b0; bus0.instr_op = '0; bus0.instr_data = '0; bus0.result_ready = 1'b0;
    bus3.instr_valid = 1'b0; bus3.instr_op = '0; bus3.instr_data = '0; bus3.result_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset instr_ready gated", 32'(bus0.instr_ready), 32'd0);
    checkOutput("reset ctl word", 32'(ctl0), 32'(C_IDLE));
    checkOutput("reset result_valid", 32'(bus0.result_valid), 32'd0);
    checkOutput("reset operand_o", 32'(opnd0), 32'd0);
    checkOutput("reset flags", 32'({fc0, fz0, err0}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // LDA 0x3C
    pushEv(C_DRIVE, 8'h3C, 1'b0, 1'b0, 1'b1);
    pushEv(C_LA,    8'h3C, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_LDA, 8'h3C);
    waitReady(3, "LDA latency");

    // LDA 0xF0 then ADD 0x20 with carry and zero raised
    pushEv(C_DRIVE, 8'hF0, 1'b0, 1'b0, 1'b1);
    pushEv(C_LA,    8'hF0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_LDA, 8'hF0);
    waitReady(3, "LDA 0xF0 latency");
    alu_cf = 1'b1;
    alu_zf = 1'b1;
    pushEv(C_DRIVE, 8'h20, 1'b0, 1'b0, 1'b1);
    pushEv(C_LB,    8'h20, 1'b0, 1'b0, 1'b1);
    pushEv(C_EXEC,  8'h20, 1'b0, 1'b0, 1'b1);
    pushEv(C_WB,    8'h20, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 8'h20);
    waitReady(5, "ADD latency");
    checkOutput("ADD flag_c", 32'(fc0), 32'd1);
    checkOutput("ADD flag_z", 32'(fz0), 32'd1);

    // SUB 0x01: sub asserted only in EXEC and WB, flags cleared
    alu_cf = 1'b0;
    alu_zf = 1'b0;
    pushEv(C_DRIVE,  8'h01, 1'b0, 1'b0, 1'b1);
    pushEv(C_LB,     8'h01, 1'b0, 1'b0, 1'b1);
    pushEv(C_EXEC_S, 8'h01, 1'b0, 1'b0, 1'b1);
    pushEv(C_WB_S,   8'h01, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_SUB, 8'h01);
    waitReady(5, "SUB latency");
    checkOutput("SUB flags", 32'({fc0, fz0}), 32'd0);

    // LDA must leave flags alone even with ALU flags high
    alu_cf = 1'b1;
    alu_zf = 1'b1;
    pushEv(C_DRIVE, 8'h11, 1'b0, 1'b0, 1'b1);
    pushEv(C_LA,    8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_LDA, 8'h11);
    waitReady(3, "LDA 0x11 latency");
    checkOutput("LDA keeps flags", 32'({fc0, fz0}), 32'd0);

    // CLR drives zero regardless of the supplied operand
    pushEv(C_DRIVE, 8'h00, 1'b0, 1'b0, 1'b1);
    pushEv(C_LA,    8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_CLR, 8'hEE);
    waitReady(3, "CLR latency");

    // OUT with consumer stalled 4 cycles, then handshake
    repeat (5) pushEv(C_OUT, 8'h77, 1'b1, 1'b0, 1'b1);
    applyStimulus(OP_OUT, 8'h77);
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus0.result_ready = 1'b1;
    @(posedge clk);
    #1 bus0.result_ready = 1'b0;
    waitReady(1, "OUT exit after handshake");

    // Illegal opcode then three back-to-back NOPs
    pushEv(C_IDLE, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'd7, 8'hAA);
    applyStimulus(OP_NOP, 8'h00);
    applyStimulus(OP_NOP, 8'h00);
    applyStimulus(OP_NOP, 8'h00);
    @(negedge clk);
    checkOutput("ready after NOPs", 32'(bus0.instr_ready), 32'd1);
    repeat (2) @(negedge clk);

    // OUT timeout on dut3 with the consumer never ready
    repeat (3) pushEv3(C_OUT, 8'h5A, 1'b1, 1'b0, 1'b1);
    pushEv3(C_IDLE, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("dut3 ready before OUT", 32'(bus3.instr_ready), 32'd1);
    bus3.instr_valid = 1'b1;
    bus3.instr_op    = OP_OUT;
    bus3.instr_data  = 8'h5A;
    @(posedge clk);
    #1 bus3.instr_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus3.instr_ready && n < 20);
    checkOutput("dut3 OUT timeout latency", 32'(n), 32'd4);

    // ADD to set flags, then reset in EXEC of a second ADD
    pushEv(C_DRIVE, 8'h10, 1'b0, 1'b0, 1'b1);
    pushEv(C_LB,    8'h10, 1'b0, 1'b0, 1'b1);
    pushEv(C_EXEC,  8'h10, 1'b0, 1'b0, 1'b1);
    pushEv(C_WB,    8'h10, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 8'h10);
    waitReady(5, "ADD 0x10 latency");
    checkOutput("flags set before reset", 32'({fc0, fz0}), 32'd3);
    pushEv(C_DRIVE, 8'h05, 1'b0, 1'b0, 1'b1);
    pushEv(C_LB,    8'h05, 1'b0, 1'b0, 1'b1);
    pushEv(C_EXEC,  8'h05, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 8'h05);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset instr_ready", 32'(bus0.instr_ready), 32'd0);
    checkOutput("mid reset flags", 32'({fc0, fz0}), 32'd0);
    checkOutput("mid reset ctl word", 32'(ctl0), 32'(C_IDLE));
    checkOutput("mid reset operand_o", 32'(opnd0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset release", 32'(bus0.instr_ready), 32'd1);

    repeat (4) @(negedge clk);
    checkOutput("dut0 events drained", 32'(q0.size()), 32'd0);
    checkOutput("dut3 events drained", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
